bounce_box_pattern: RTL
=======================

// Module: bounce_box_pattern
// PURPOSE
//   Pixel-pattern source that drives the colour-index input of the video_top colour LUT (3-bit index -> 24-bit BGR).
//   Draws a BOX_W x BOX_H box on a background. The box moves STEP_X/STEP_Y pixels per frame and bounces off the active-area edges.
//   Its colour index advances on every bounce. Position updates only at frame start, inside vertical blanking, so there is no tearing.
// PARAMETERS
//   H_ACTIVE  1280  active pixels per line
//   V_ACTIVE  720   active lines per frame
//   BOX_W     64    box width in pixels; legal range 1..H_ACTIVE-1
//   BOX_H     64    box height in lines; legal range 1..V_ACTIVE-1
//   STEP_X    2     horizontal move per frame; legal range 1..H_ACTIVE-BOX_W
//   STEP_Y    2     vertical move per frame; legal range 1..V_ACTIVE-BOX_H
//   BG_IDX    3'd7  background colour index (black)
// PORTS
//   pxClk         in   1   pixel clock
//   I_rst_n       in   1   asynchronous, active-low reset
//   I_hor_cnt     in   12  horizontal counter from video_controller
//   I_ver_cnt     in   12  vertical counter from video_controller
//   I_enable      in   1   1 = motion runs; 0 = position, direction and colour frozen
//   O_color_idx   out  3   colour index for the LUT, registered
//   O_frame_tick  out  1   1-cycle pulse at each frame start
//   O_bounce_cnt  out  16  count of bounce events
// BEHAVIOUR
//   Reset values:
//     - O_color_idx = BG_IDX, O_frame_tick = 0, O_bounce_cnt = 0
//     - box_x = 0, box_y = 0, dir_x = +, dir_y = +, box_idx = 0
//   Frame tick:
//     - Asserted for one cycle on the first cycle where (I_ver_cnt == V_ACTIVE && I_hor_cnt == 0).
//     - Edge-detected against the previous cycle's match, so counters held at that value give one pulse, not many.
//   Motion: on the cycle after O_frame_tick, if I_enable = 1:
//     - X moving +: if box_x + STEP_X >= H_ACTIVE-BOX_W, clamp box_x = H_ACTIVE-BOX_W, dir_x = -, hit_x = 1.
//       Otherwise box_x += STEP_X.
//     - X moving -: if box_x <= STEP_X, clamp box_x = 0, dir_x = +, hit_x = 1. Otherwise box_x -= STEP_X.
//     - Y axis: identical logic with box_y, STEP_Y, V_ACTIVE, BOX_H, producing hit_y.
//     - Any hit (hit_x | hit_y):
//       - box_idx += 1 mod 8; if the result equals BG_IDX, add 1 more.
//       - O_bounce_cnt += 1 (wraps 0xFFFF -> 0).
//       - A corner hit (both axes in the same frame) counts once and advances the colour once.
//   Pixel path (1-cycle latency from I_hor_cnt/I_ver_cnt to O_color_idx):
//     - If hor >= H_ACTIVE or ver >= V_ACTIVE: BG_IDX.
//     - Else if box_x <= hor < box_x+BOX_W and box_y <= ver < box_y+BOX_H: box_idx.
//     - Else: BG_IDX.
//     - All comparisons are unsigned, 13-bit, so edge sums do not overflow.
//   Other rules:
//     - I_enable = 0: O_frame_tick still pulses; the box is drawn at the frozen position.
//     - Reset mid-frame: all state returns to reset values immediately. Motion resumes on the next frame tick.
// TESTING
//   1. Reset, then run 3 frames, I_enable=1 -> box_x = box_y = 6; pixel (6,6) gives idx 0; pixel (5,6) gives 7.
//   2. Preload x = 1214, dir + -> next tick: box_x = 1216, dir_x = -, box_idx = 1, O_bounce_cnt = 1.
//   3. Corner: x = 1215, y = 655, both moving + -> x = 1216, y = 656, bounce_cnt += 1, box_idx += 1 (once only).
//   4. box_idx = 6, BG_IDX = 7, then a bounce -> box_idx = 0 (7 skipped).
//   5. I_enable = 0 for 5 frames -> position and colour unchanged; exactly 5 O_frame_tick pulses.
//   6. Hold counters at (0,720) for 10 cycles -> one tick. Assert I_rst_n mid-line -> all outputs and state at reset values.

Source files
------------

// File: rtl/bounce_box_pattern.sv
// bounce_box_pattern: bouncing box pattern source feeding the colour LUT index
module bounce_box_pattern #(
  parameter int         H_ACTIVE = 1280,
  parameter int         V_ACTIVE = 720,
  parameter int         BOX_W    = 64,
  parameter int         BOX_H    = 64,
  parameter int         STEP_X   = 2,
  parameter int         STEP_Y   = 2,
  parameter logic [2:0] BG_IDX   = 3'd7
) (
  input  logic        pxClk,
  input  logic        I_rst_n,
  input  logic [11:0] I_hor_cnt,
  input  logic [11:0] I_ver_cnt,
  input  logic        I_enable,
  output logic [2:0]  O_color_idx,
  output logic        O_frame_tick,
  output logic [15:0] O_bounce_cnt
);
  localparam logic [12:0] HA   = 13'(H_ACTIVE);
  localparam logic [12:0] VA   = 13'(V_ACTIVE);
  localparam logic [12:0] BW   = 13'(BOX_W);
  localparam logic [12:0] BH   = 13'(BOX_H);
  localparam logic [12:0] SX   = 13'(STEP_X);
  localparam logic [12:0] SY   = 13'(STEP_Y);
  localparam logic [12:0] XMAX = 13'(H_ACTIVE - BOX_W);
  localparam logic [12:0] YMAX = 13'(V_ACTIVE - BOX_H);

  logic        r_match_d;
  logic [12:0] r_box_x, r_box_y;
  logic        r_neg_x, r_neg_y;
  logic [2:0]  r_box_idx;
  logic        w_match, w_hit_x, w_hit_y, w_in_box;
  logic [12:0] w_nx, w_ny, w_hor, w_ver;
  logic [2:0]  w_idx_inc, w_nidx;

  assign w_match = (I_ver_cnt == 12'(V_ACTIVE)) && (I_hor_cnt == 12'd0);

  // Next box position/direction/colour and the current pixel's box membership
  always_comb begin
    w_hit_x   = r_neg_x ? (r_box_x <= SX) : (r_box_x + SX >= XMAX);
    w_hit_y   = r_neg_y ? (r_box_y <= SY) : (r_box_y + SY >= YMAX);
    w_nx      = w_hit_x ? (r_neg_x ? 13'd0 : XMAX) : (r_neg_x ? r_box_x - SX : r_box_x + SX);
    w_ny      = w_hit_y ? (r_neg_y ? 13'd0 : YMAX) : (r_neg_y ? r_box_y - SY : r_box_y + SY);
    w_idx_inc = r_box_idx + 3'd1;
    w_nidx    = (w_idx_inc == BG_IDX) ? w_idx_inc + 3'd1 : w_idx_inc;
    w_hor     = {1'b0, I_hor_cnt};
    w_ver     = {1'b0, I_ver_cnt};
    w_in_box  = (w_hor < HA) && (w_ver < VA) && (w_hor >= r_box_x) && (w_hor < r_box_x + BW) &&
                (w_ver >= r_box_y) && (w_ver < r_box_y + BH);
  end

  // Single-cycle frame tick on the rising edge of the frame-start match
  always_ff @(posedge pxClk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_match_d    <= 1'b0;
      O_frame_tick <= 1'b0;
    end else begin
      r_match_d    <= w_match;
      O_frame_tick <= w_match && !r_match_d;
    end
  end

  // Box motion, bounce colour advance and bounce counting once per frame
  always_ff @(posedge pxClk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_box_x      <= 13'd0;
      r_box_y      <= 13'd0;
      r_neg_x      <= 1'b0;
      r_neg_y      <= 1'b0;
      r_box_idx    <= 3'd0;
      O_bounce_cnt <= 16'd0;
    end else if (O_frame_tick && I_enable) begin
      r_box_x <= w_nx;
      r_box_y <= w_ny;
      r_neg_x <= r_neg_x ^ w_hit_x;
      r_neg_y <= r_neg_y ^ w_hit_y;
      if (w_hit_x || w_hit_y) begin
        r_box_idx    <= w_nidx;
        O_bounce_cnt <= O_bounce_cnt + 16'd1;
      end
    end
  end

  // Registered pixel colour index
  always_ff @(posedge pxClk or negedge I_rst_n) begin
    if (!I_rst_n) O_color_idx <= BG_IDX;
    else          O_color_idx <= w_in_box ? r_box_idx : BG_IDX;
  end
endmodule
